event_code_encoder: RTL and testbench



---
 rtl/event_code_encoder.sv | 87 ++++++++
 tb/tb_event_code_encoder.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/event_code_encoder.sv
// Event strobe collector and binary code emitter over a valid/ready stream.
// Optional round-robin selection via `define EVENT_CODE_ENCODER_RR_EN (default: fixed priority, lowest index).
module event_code_encoder #(
  parameter  int N = 8,
  localparam int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic [N-1:0] i_event,
  input  logic         i_clear,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [W-1:0] o_code,
  output logic [N-1:0] o_pending,
  output logic         o_overflow
);

  logic [N-1:0] pending;
  logic [N-1:0] load_mask;
  logic [W-1:0] sel;
  logic         slot_free;
  logic         any_pending;
  logic         load;

  assign o_pending   = pending;
  assign slot_free   = !o_valid || i_ready;
  assign any_pending = |pending;
  assign load        = slot_free && any_pending;

`ifdef EVENT_CODE_ENCODER_RR_EN
  logic [W-1:0] ptr;

  // Scan offsets from the far end so the first pending index at/after ptr is the last one written.
  always_comb begin
    // NOTE: default assignment first so no path leaves sel unassigned (no latch).
    sel = '0;
    for (int off = N - 1; off >= 0; off--) begin
      if (pending[(int'(ptr) + off) % N]) sel = W'((int'(ptr) + off) % N);
    end
  end

  // Pointer survives i_clear; only reset returns it to 0.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ptr <= '0;
    end else if (!i_clear && load) begin
      ptr <= (sel == W'(N - 1)) ? '0 : sel + 1'b1;
    end
  end
`else
  // Lowest pending index wins: the downward scan leaves the smallest set index in sel.
  always_comb begin
    sel = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (pending[i]) sel = W'(i);
    end
  end
`endif

  always_comb begin
    load_mask = '0;
    if (load) load_mask[sel] = 1'b1;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pending    <= '0;
      o_valid    <= 1'b0;
      o_code     <= '0;
      o_overflow <= 1'b0;
    end else if (i_clear) begin
      pending    <= '0;
      o_valid    <= 1'b0;
      o_overflow <= 1'b0;
    end else begin
      // NOTE: non-blocking updates so every term below reads the pre-edge pending value.
      // A new strobe re-sets a bit even when that bit is being loaded this cycle.
      pending <= (pending & ~load_mask) | i_event;
      if (|(i_event & pending)) o_overflow <= 1'b1;
      if (slot_free) begin
        o_valid <= any_pending;
        if (any_pending) o_code <= sel;
      end
    end
  end

endmodule

// File: tb/tb_event_code_encoder.sv
// Self-checking bench for event_code_encoder: directed test-plan steps plus random traffic vs a reference model.
// Honours `define EVENT_CODE_ENCODER_RR_EN to select the expected arbitration policy.
module tb_event_code_encoder;

  localparam int N = 8;
  localparam int W = 3;

`ifdef EVENT_CODE_ENCODER_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] ev;
  logic         clr;
  logic         rdy;
  logic         valid;
  logic [W-1:0] code;
  logic [N-1:0] pend;
  logic         ovf;

  int passed = 0;
  int fails  = 0;
  int total  = 0;

  // Reference model state
  bit [N-1:0] m_pending;
  bit         m_valid;
  int         m_code;
  bit         m_ovf;
  int         m_ptr;
  int         accepted[$];

  event_code_encoder #(.N(N)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_event    (ev),
    .i_clear    (clr),
    .o_valid    (valid),
    .i_ready    (rdy),
    .o_code     (code),
    .o_pending  (pend),
    .o_overflow (ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pending = '0;
    m_valid   = 1'b0;
    m_code    = 0;
    m_ovf     = 1'b0;
    m_ptr     = 0;
  endtask

  // One clock of the reference behaviour, from the pre-edge state and this cycle's inputs.
  task automatic model_step(input bit [N-1:0] e, input bit r, input bit c);
    bit free;
    int k;
    if (c) begin
      m_pending = '0;
      m_valid   = 1'b0;
      m_ovf     = 1'b0;
      return;
    end
    if (m_valid && r) accepted.push_back(m_code);
    free = !m_valid || r;
    k = -1;
    if (free && m_pending != 0) begin
      for (int n = 0; n < N; n++) begin
        int idx;
        idx = RR ? (m_ptr + n) % N : n;
        if (k < 0 && m_pending[idx]) k = idx;
      end
    end
    if ((e & m_pending) != 0) m_ovf = 1'b1;
    if (k >= 0) m_pending[k] = 1'b0;
    m_pending = m_pending | e;
    if (free) begin
      if (k >= 0) begin
        m_valid = 1'b1;
        m_code  = k;
        if (RR) m_ptr = (k + 1) % N;
      end else begin
        m_valid = 1'b0;
      end
    end
  endtask

  task automatic step(input logic [N-1:0] e, input logic r, input logic c);
    ev  = e;
    rdy = r;
    clr = c;
    model_step(e, r, c);
    @(posedge clk);
    #1;
    check("model_valid",   64'(valid), 64'(m_valid));
    check("model_code",    64'(code),  64'(m_code));
    check("model_pending", 64'(pend),  64'(m_pending));
    check("model_overflow",64'(ovf),   64'(m_ovf));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    ev    = '0;
    rdy   = 1'b0;
    clr   = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    ev    = '0;
    rdy   = 1'b0;
    clr   = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_valid",    64'(valid), 64'(0));
    check("reset_code",     64'(code),  64'(0));
    check("reset_pending",  64'(pend),  64'(0));
    check("reset_overflow", 64'(ovf),   64'(0));
    rst_n = 1'b1;

    // Single strobe: code 4 appears two cycles after the strobe, for one cycle.
    step(8'h10, 1'b1, 1'b0);
    check("single_pending_set", 64'(pend), 64'h10);
    step(8'h00, 1'b1, 1'b0);
    check("single_valid", 64'(valid), 64'(1));
    check("single_code",  64'(code),  64'(4));
    check("single_pending_clear", 64'(pend), 64'(0));
    step(8'h00, 1'b1, 1'b0);
    check("single_valid_drop", 64'(valid), 64'(0));

    // Two events: 0 then 7 back to back.
    step(8'h81, 1'b1, 1'b0);
    step(8'h00, 1'b1, 1'b0);
    check("pair_first_code", 64'(code), 64'(0));
    step(8'h00, 1'b1, 1'b0);
    check("pair_second_valid", 64'(valid), 64'(1));
    check("pair_second_code",  64'(code),  64'(7));
    step(8'h00, 1'b1, 1'b0);
    check("pair_done", 64'(valid), 64'(0));

    // Stall: re-strobe of the held event is not an overflow.
    step(8'h02, 1'b0, 1'b0);
    step(8'h00, 1'b0, 1'b0);
    check("stall_code", 64'(code), 64'(1));
    step(8'h00, 1'b0, 1'b0);
    step(8'h02, 1'b0, 1'b0);
    check("stall_code_held",  64'(code),  64'(1));
    check("stall_valid_held", 64'(valid), 64'(1));
    check("stall_repend",     64'(pend),  64'h02);
    check("stall_no_ovf",     64'(ovf),   64'(0));
    step(8'h00, 1'b1, 1'b0);
    check("stall_release_code",  64'(code),  64'(1));
    check("stall_release_valid", 64'(valid), 64'(1));
    step(8'h00, 1'b1, 1'b0);
    check("stall_release_done", 64'(valid), 64'(0));

    // Overflow: strobe an already-pending event while the slot is blocked.
    step(8'h01, 1'b0, 1'b0);
    step(8'h00, 1'b0, 1'b0);
    step(8'h04, 1'b0, 1'b0);
    step(8'h04, 1'b0, 1'b0);
    check("ovf_set", 64'(ovf), 64'(1));
    step(8'h00, 1'b0, 1'b0);
    check("ovf_sticky", 64'(ovf), 64'(1));
    step(8'h00, 1'b0, 1'b1);
    check("ovf_cleared", 64'(ovf), 64'(0));

    // Saturated pending with ready: policy-dependent code order.
    do_reset();
    step(8'hFF, 1'b1, 1'b0);
    for (int i = 0; i < 9; i++) begin
      step(8'hFF, 1'b1, 1'b0);
      check("sat_code", 64'(code), RR ? 64'(i % N) : 64'(0));
    end

    // Clear beats a same-cycle strobe and drops the held code.
    do_reset();
    step(8'h02, 1'b0, 1'b0);
    step(8'h30, 1'b0, 1'b0);
    check("clr_setup_pending", 64'(pend),  64'h30);
    check("clr_setup_valid",   64'(valid), 64'(1));
    step(8'h01, 1'b1, 1'b1);
    check("clr_valid",   64'(valid), 64'(0));
    check("clr_pending", 64'(pend),  64'(0));
    check("clr_ovf",     64'(ovf),   64'(0));
    step(8'h00, 1'b1, 1'b0);
    check("clr_no_code0", 64'(valid), 64'(0));

    // Asynchronous reset mid-cycle while code 3 is held.
    step(8'h08, 1'b0, 1'b0);
    step(8'h00, 1'b0, 1'b0);
    check("areset_setup_code", 64'(code), 64'(3));
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("areset_valid", 64'(valid), 64'(0));
    check("areset_code",  64'(code),  64'(0));
    check("areset_pend",  64'(pend),  64'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(8'h00, 1'b1, 1'b0);
      check("areset_quiet", 64'(valid), 64'(0));
    end

    // Random traffic against the model.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      logic [N-1:0] e;
      e = N'($urandom & $urandom & $urandom);
      step(e, ($urandom_range(0, 3) != 0), ($urandom_range(0, 40) == 0));
    end
    // Drain and confirm every accepted code is a legal index.
    for (int i = 0; i < 12; i++) step(8'h00, 1'b1, 1'b0);
    check("drain_empty", 64'(valid), 64'(0));
    foreach (accepted[j]) begin
      if (accepted[j] >= N) check("legal_code", 64'(accepted[j]), 64'(N - 1));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
